// File: rtl/conv1d_multi_filter_engine.sv
// conv1d_multi_filter_engine: NUM_FILTERS parallel PEs slide FILT_LEN-tap windows over a buffered image.
// Optional CONV_OUT_SAT_EN clamps each emitted result to 2**DATA_W-1.
module conv1d_multi_filter_engine #(
  parameter int NUM_FILTERS = 4,
  parameter int FILT_LEN    = 4,
  parameter int IMG_LEN     = 16,
  parameter int DATA_W      = 8,
  parameter int STRIDE      = 1,
  parameter int ACC_W       = 2*DATA_W + $clog2(FILT_LEN),
  localparam int NUM_OUT    = (IMG_LEN - FILT_LEN) / STRIDE + 1,
  localparam int SEL_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int IDX_W      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1,
  localparam int POS_W      = $clog2(NUM_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              filt_wr_en,
  input  logic [SEL_W-1:0]  filt_wr_sel,
  input  logic [IDX_W-1:0]  filt_wr_idx,
  input  logic [DATA_W-1:0] filt_wr_data,
  input  logic              img_valid,
  output logic              img_ready,
  input  logic [DATA_W-1:0] img_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_filter,
  output logic [POS_W-1:0]  out_pos,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);
  localparam int IMG_AW = (IMG_LEN > 1) ? $clog2(IMG_LEN) : 1;
`ifdef CONV_OUT_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);
`endif

  // state | meaning
  // IDLE  | waiting for start; coefficient writes accepted
  // LOAD  | accepting IMG_LEN image samples
  // MAC   | FILT_LEN multiply-accumulate cycles for the current window
  // EMIT  | one result beat per filter, held while out_ready is low
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_EMIT, S_DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] coef [NUM_FILTERS][FILT_LEN];
  logic [DATA_W-1:0] img  [IMG_LEN];
  logic [ACC_W-1:0]  acc  [NUM_FILTERS];
  logic [IMG_AW-1:0] load_idx, base, tap_addr;
  logic [IDX_W-1:0]  tap;
  logic [POS_W-1:0]  pos;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] sample;
  logic [ACC_W-1:0]  acc_sel;
  logic              img_fire, load_last, tap_last, emit_fire, sel_last, pos_last, wr_ok;

  assign img_fire  = (state == S_LOAD) && img_valid;
  assign load_last = img_fire && (load_idx == IMG_AW'(IMG_LEN - 1));
  assign tap_last  = (tap == IDX_W'(FILT_LEN - 1));
  assign emit_fire = (state == S_EMIT) && out_ready;
  assign sel_last  = (sel == SEL_W'(NUM_FILTERS - 1));
  assign pos_last  = (pos == POS_W'(NUM_OUT - 1));
  assign wr_ok     = filt_wr_en && (int'(filt_wr_sel) < NUM_FILTERS) && (int'(filt_wr_idx) < FILT_LEN);
  // base tracks pos*STRIDE incrementally, so no multiplier sits in the address path
  assign tap_addr  = base + IMG_AW'(tap);
  assign sample    = img[tap_addr];
  assign acc_sel   = acc[sel];
  assign out_filter = sel;
  assign out_pos    = pos;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    img_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        img_ready = 1'b1;
        if (load_last) state_nx = S_MAC;
      end
      S_MAC: if (tap_last) state_nx = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
`ifdef CONV_OUT_SAT_EN
        out_data = (acc_sel > SAT_MAX) ? SAT_MAX : acc_sel;
`else
        out_data = acc_sel;
`endif
        if (emit_fire && sel_last) state_nx = pos_last ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        acc[f] <= '0;
        for (int k = 0; k < FILT_LEN; k++) coef[f][k] <= '0;
      end
      for (int i = 0; i < IMG_LEN; i++) img[i] <= '0;
      load_idx <= '0;
      base     <= '0;
      tap      <= '0;
      pos      <= '0;
      sel      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_ok) coef[filt_wr_sel][filt_wr_idx] <= filt_wr_data;
          load_idx <= '0;
          base     <= '0;
          tap      <= '0;
          pos      <= '0;
          sel      <= '0;
        end
        S_LOAD: if (img_fire) begin
          img[load_idx] <= img_data;
          load_idx      <= load_last ? '0 : load_idx + 1'b1;
          if (load_last)
            for (int f = 0; f < NUM_FILTERS; f++) acc[f] <= '0;
        end
        S_MAC: begin
          for (int f = 0; f < NUM_FILTERS; f++)
            acc[f] <= acc[f] + ACC_W'(coef[f][tap]) * ACC_W'(sample);
          tap <= tap_last ? '0 : tap + 1'b1;
          sel <= '0;
        end
        S_EMIT: if (emit_fire) begin
          if (sel_last) begin
            sel <= '0;
            if (!pos_last) begin
              pos  <= pos + 1'b1;
              base <= base + IMG_AW'(STRIDE);
              for (int f = 0; f < NUM_FILTERS; f++) acc[f] <= '0;
            end
          end else begin
            sel <= sel + 1'b1;
          end
        end
        S_DONE: begin
          pos  <= '0;
          base <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
